// File: rtl/parity_sched_pkg.sv
// Shared types and helpers for the round-robin parity scheduler.
package parity_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } sched_state_t;

    // Saturating increment; the caller supplies the all-ones ceiling of its counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/parity_rr_scheduler_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, modulo R.
module rr_arbiter_rr #(
    parameter  int R   = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_any
);

    // Scan from the farthest offset down so the closest request to ptr is written last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = R - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % R;
            if (req[idx]) begin
                gnt_idx = IDW'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_rr_scheduler.sv
// Round-robin shared parity engine: one burst at a time, one result per burst.
module parity_rr_scheduler
    import parity_sched_pkg::*;
#(
    parameter  int N   = 8,
    parameter  int R   = 4,
    parameter  int CW  = 16,
    localparam int IDW = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    input  logic [R*N-1:0] req_data,
    input  logic [R-1:0]   req_last,
    output logic [R-1:0]   req_ready,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_parity,
    output logic [IDW-1:0] res_id,
    output logic [CW-1:0]  res_count,
    output logic           busy
);

    sched_state_t   state;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] arb_idx;
    logic           arb_any;
    logic           acc;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   word;
    logic           beat;

    rr_arbiter_rr #(.R(R)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign word = req_data[int'(gnt) * N +: N];
    assign beat = (state == ACCUM) && req_valid[gnt];

    // NOTE: async reset plus non-blocking assignments for every state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
            acc    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt   <= arb_idx;
                        acc   <= 1'b0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= acc ^ (^word);
                        cnt <= CW'(sat_inc(32'(cnt), 32'({CW{1'b1}})));
                        if (req_last[gnt]) state <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        rr_ptr <= (gnt == IDW'(R - 1)) ? '0 : gnt + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: default assignment first keeps this decode free of inferred latches.
    always_comb begin
        req_ready = '0;
        if (state == ACCUM) req_ready[gnt] = 1'b1;
    end

    assign res_valid  = (state == RESULT);
    assign res_parity = acc;
    assign res_id     = gnt;
    assign res_count  = cnt;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop and compare on handshake.
module tb_parity_rr_scheduler;

    typedef struct {
        logic        parity;
        logic [1:0]  id;
        logic [15:0] count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        res_valid, res_ready, res_parity, busy;
    logic [1:0]  res_id;
    logic [15:0] res_count;

    logic [3:0]  s_req_valid, s_req_last, s_req_ready;
    logic [31:0] s_req_data;
    logic        s_res_valid, s_res_ready, s_res_parity, s_busy;
    logic [1:0]  s_res_id;
    logic [1:0]  s_res_count;

    int total = 0;
    int bad = 0;
    int n_results = 0;
    exp_t q[$];
    exp_t qs[$];
    logic [7:0] bw[8];

    parity_rr_scheduler #(.N(8), .R(4), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
        .res_ready(res_ready), .res_parity(res_parity), .res_id(res_id),
        .res_count(res_count), .busy(busy)
    );

    parity_rr_scheduler #(.N(8), .R(4), .CW(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_data(s_req_data),
        .req_last(s_req_last), .req_ready(s_req_ready), .res_valid(s_res_valid),
        .res_ready(s_res_ready), .res_parity(s_res_parity), .res_id(s_res_id),
        .res_count(s_res_count), .busy(s_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 0, 1);
                end else begin
                    e = q.pop_front();
                    check("res_parity", res_parity, e.parity);
                    check("res_id", res_id, e.id);
                    check("res_count", res_count, e.count);
                    n_results++;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && s_res_valid && s_res_ready) begin
            if (qs.size() == 0) begin
                check("small_unexpected_result", 0, 1);
            end else begin
                e = qs.pop_front();
                check("small_res_parity", s_res_parity, e.parity);
                check("small_res_id", s_res_id, e.id);
                check("small_res_count", s_res_count, e.count[1:0]);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_parity"}, res_parity, 0);
        check({tag, "_res_id"}, res_id, 0);
        check({tag, "_res_count"}, res_count, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (q.size() == 0 && qs.size() == 0 && !busy && !s_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    task automatic wait_results(input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (n_results >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("result_timeout", ok, 1);
    endtask

    // Drives words bw[0..n-1] from requester id; expected parity is folded from the words.
    task automatic burst(input int id, input int n);
        exp_t e;
        logic p;
        bit   ok;
        p = 1'b0;
        for (int i = 0; i < n; i++) p = p ^ (^bw[i]);
        e.parity = p;
        e.id     = 2'(id);
        e.count  = 16'(n);
        q.push_back(e);
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        for (int i = 0; i < n; i++) begin
            req_data[id*8 +: 8] = bw[i];
            req_last[id] = (i == n - 1);
            wait_ready(id, ok);
            if (!ok) break;
            @(posedge clk); #1;
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
        @(negedge clk);
        check("res_latency", res_valid, 1);
    endtask

    initial begin
        exp_t e;
        int   base;
        int   beats;
        bit   ok;

        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b1;
        s_req_valid = '0; s_req_last = '0; s_req_data = '0; s_res_ready = 1'b1;
        #1;
        check_zero("in_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after_reset");

        // Three-beat burst from requester 0.
        bw[0] = 8'h01; bw[1] = 8'h03; bw[2] = 8'h07;
        burst(0, 3);
        wait_idle();

        // Fresh pointer, then every requester streams single-beat bursts.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
        for (int i = 0; i < 5; i++) begin
            e.id     = 2'(i % 4);
            e.parity = ^req_data[(i % 4)*8 +: 8];
            e.count  = 16'd1;
            q.push_back(e);
        end
        base = n_results;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        wait_results(base + 5);
        req_valid = '0;
        req_last  = '0;
        wait_idle();

        // Consumer stalls: result must hold steady and block new grants.
        res_ready = 1'b0;
        bw[0] = 8'h0F; bw[1] = 8'h01;
        burst(3, 2);
        for (int c = 0; c < 5; c++) begin
            check("hold_res_valid", res_valid, 1);
            check("hold_res_parity", res_parity, 1);
            check("hold_res_id", res_id, 3);
            check("hold_res_count", res_count, 2);
            check("hold_req_ready", req_ready, 0);
            check("hold_busy", busy, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_idle();
        check("released_busy", busy, 0);

        // Single-beat bursts at the parity extremes.
        bw[0] = 8'hFF;
        burst(1, 1);
        wait_idle();
        bw[0] = 8'h80;
        burst(2, 1);
        wait_idle();

        // Reset in the middle of a requester 2 burst.
        @(posedge clk); #1;
        req_data[23:16] = 8'h01;
        req_valid[2] = 1'b1;
        req_last[2]  = 1'b0;
        beats = 0;
        ok = 1'b1;
        while (beats < 2 && ok) begin
            wait_ready(2, ok);
            if (ok) beats++;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_burst_reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data = {8'h07, 8'h00, 8'h03, 8'h00};
        e.id = 2'd1; e.parity = 1'b0; e.count = 16'd1; q.push_back(e);
        e.id = 2'd3; e.parity = 1'b1; e.count = 16'd1; q.push_back(e);
        base = n_results;
        @(posedge clk); #1;
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        wait_results(base + 2);
        req_valid = '0;
        req_last  = '0;
        wait_idle();

        // Narrow counter: five beats of 0x01 saturate a 2-bit count.
        e.id = 2'd0; e.parity = 1'b1; e.count = 16'd3; qs.push_back(e);
        @(posedge clk); #1;
        s_req_valid[0]  = 1'b1;
        s_req_data[7:0] = 8'h01;
        for (int i = 0; i < 5; i++) begin
            s_req_last[0] = (i == 4);
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (s_req_ready[0]) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("small_ready_timeout", ok, 1);
            @(posedge clk); #1;
        end
        s_req_valid = '0;
        s_req_last  = '0;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
